// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
package fetch_pkg;
   typedef enum logic [1:0] {FETCH, WAIT, DROP} fetch_state_t;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
   localparam int FETCH_DEPTH = 2;
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry instruction buffer with push, pop, clear and occupancy count.
module fetch_fifo
   import fetch_pkg::*;
(
   input  logic         CLK,
   input  logic         RESET,
   input  logic         push,
   input  logic         pop,
   input  logic         clear,
   input  fetch_entry_t push_entry,
   output fetch_entry_t head,
   output logic [1:0]   count
);
   fetch_entry_t mem [FETCH_DEPTH];
   logic rd_ptr, wr_ptr;
   logic do_push, do_pop;
   assign do_pop = pop && count != 2'd0;
   assign do_push = push && (count != 2'(FETCH_DEPTH) || do_pop);
   assign head = mem[rd_ptr];
   always_ff @(posedge CLK or negedge RESET)
      if (!RESET) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count <= 2'd0;
         mem[0] <= '0;
         mem[1] <= '0;
      end else if (clear) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count <= 2'd0;
      end else begin
         if (do_push) mem[wr_ptr] <= push_entry;
         wr_ptr <= wr_ptr ^ do_push;
         rd_ptr <= rd_ptr ^ do_pop;
         count <= count + {1'b0, do_push} - {1'b0, do_pop};
      end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner issuing one-outstanding word reads and buffering
// returned instructions for the IF/ID register, with flush/redirect handling.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        STALL,
   input  logic        FLUSH,
   input  logic        REDIRECT_VALID,
   input  logic [31:0] REDIRECT_PC,
   output logic        IMEM_REQ,
   output logic [31:0] IMEM_ADDR,
   input  logic        IMEM_READY,
   input  logic        IMEM_RVALID,
   input  logic [31:0] IMEM_RDATA,
   output logic [31:0] Instr1_IF,
   output logic [31:0] Instr_PC_IF,
   output logic [31:0] Instr_PC_Plus4_IF,
   output logic        Instr_VALID_IF
);
   fetch_state_t state, state_nxt;
   logic [31:0] pc, pc_nxt, inflight_pc;
   logic [1:0] count;
   fetch_entry_t head;
   logic kill, accept, push, head_valid;
   assign kill = FLUSH || REDIRECT_VALID;
   assign head_valid = count != 2'd0;
   assign IMEM_ADDR = pc;
   assign accept = IMEM_REQ && IMEM_READY;
   assign push = state == WAIT && IMEM_RVALID && !kill;
   always_comb begin
      IMEM_REQ = RESET && state == FETCH && count < 2'(FETCH_DEPTH) && !kill;
      state_nxt = state == FETCH ? (IMEM_REQ && IMEM_READY ? WAIT : FETCH)
                : IMEM_RVALID ? FETCH
                : state == WAIT && kill ? DROP : state;
      // flush replays from the oldest instruction not yet consumed downstream
      pc_nxt = REDIRECT_VALID ? REDIRECT_PC & ~32'd3
             : FLUSH ? (head_valid ? head.pc : state == WAIT ? inflight_pc : pc)
             : IMEM_REQ && IMEM_READY ? pc + 32'd4 : pc;
   end
   always_ff @(posedge CLK or negedge RESET)
      if (!RESET) begin
         state <= FETCH;
         pc <= RESET_PC;
         inflight_pc <= '0;
      end else begin
         state <= state_nxt;
         pc <= pc_nxt;
         if (accept) inflight_pc <= pc;
      end
   fetch_fifo u_fifo (
      .CLK        (CLK),
      .RESET      (RESET),
      .push       (push),
      .pop        (!STALL),
      .clear      (kill),
      .push_entry ('{instr: IMEM_RDATA, pc: inflight_pc}),
      .head       (head),
      .count      (count)
   );
   assign Instr_VALID_IF = head_valid;
   assign Instr1_IF = head_valid ? head.instr : '0;
   assign Instr_PC_IF = head_valid ? head.pc : '0;
   assign Instr_PC_Plus4_IF = head_valid ? head.pc + 32'd4 : '0;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: memory model returning ~addr, expected sequential
// instruction stream queue, and a monitor checking every consumed head entry.
module tb_instr_fetch_unit;
   localparam logic [31:0] RST_PC = 32'h0040_0000;
   logic CLK = 0, RESET = 0, STALL = 0, FLUSH = 0, REDIRECT_VALID = 0;
   logic IMEM_READY = 0, IMEM_RVALID = 0;
   logic [31:0] REDIRECT_PC = '0, IMEM_RDATA = '0;
   logic IMEM_REQ, Instr_VALID_IF;
   logic [31:0] IMEM_ADDR, Instr1_IF, Instr_PC_IF, Instr_PC_Plus4_IF;
   int n_pass = 0, n_chk = 0, n_acc = 0, n_cons = 0;
   logic [31:0] pend_q[$], exp_q[$];
   logic [31:0] exp_tail, prev_addr, mon_e;
   bit prev_hold;

   instr_fetch_unit dut (
      .CLK               (CLK),
      .RESET             (RESET),
      .STALL             (STALL),
      .FLUSH             (FLUSH),
      .REDIRECT_VALID    (REDIRECT_VALID),
      .REDIRECT_PC       (REDIRECT_PC),
      .IMEM_REQ          (IMEM_REQ),
      .IMEM_ADDR         (IMEM_ADDR),
      .IMEM_READY        (IMEM_READY),
      .IMEM_RVALID       (IMEM_RVALID),
      .IMEM_RDATA        (IMEM_RDATA),
      .Instr1_IF         (Instr1_IF),
      .Instr_PC_IF       (Instr_PC_IF),
      .Instr_PC_Plus4_IF (Instr_PC_Plus4_IF),
      .Instr_VALID_IF    (Instr_VALID_IF)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h, want %h", name, act, req);
   endtask

   task automatic refill();
      while (exp_q.size() < 4) begin
         exp_q.push_back(exp_tail);
         exp_tail += 32'd4;
      end
   endtask

   task automatic model_reset(input logic [31:0] start);
      pend_q.delete();
      exp_q.delete();
      exp_tail = start;
      prev_hold = 0;
      refill();
   endtask

   // one clock cycle of stimulus; the memory answers the oldest accepted read when rv is set
   task automatic step(input bit stall, input bit flush, input bit redir, input logic [31:0] rpc,
                       input bit ready, input bit rv, input bit junk);
      @(negedge CLK);
      STALL = stall;
      FLUSH = flush;
      REDIRECT_VALID = redir;
      REDIRECT_PC = rpc;
      IMEM_READY = ready;
      IMEM_RVALID = 0;
      IMEM_RDATA = $urandom;
      if (junk) begin
         IMEM_RVALID = 1;
         IMEM_RDATA = 32'hDEAD_BEEF;
      end else if (rv && pend_q.size() > 0) begin
         IMEM_RVALID = 1;
         IMEM_RDATA = ~pend_q.pop_front();
      end
      #1;
      if (prev_hold && !flush && !redir) check("req_hold", {IMEM_REQ, IMEM_ADDR}, {1'b1, prev_addr});
      prev_hold = IMEM_REQ && !ready;
      prev_addr = IMEM_ADDR;
      if (IMEM_REQ && ready) begin
         pend_q.push_back(IMEM_ADDR);
         n_acc++;
      end
      if (redir) begin
         exp_q.delete();
         exp_tail = rpc & ~32'd3;
      end
      refill();
   endtask

   // consumption at a flush/redirect edge does not count: that instruction is replayed or abandoned
   always @(negedge CLK) begin
      #2;
      if (RESET) begin
         if (!Instr_VALID_IF)
            check("empty_zero", {Instr1_IF, Instr_PC_IF, Instr_PC_Plus4_IF}, '0);
         else if (!STALL && !FLUSH && !REDIRECT_VALID) begin
            if (exp_q.size() == 0) check("exp_empty", 1, 0);
            else begin
               mon_e = exp_q.pop_front();
               check("head", {Instr1_IF, Instr_PC_IF, Instr_PC_Plus4_IF}, {~mon_e, mon_e, mon_e + 32'd4});
               n_cons++;
            end
         end
      end
   end

   initial begin
      int a0, k;
      logic [31:0] a_hold, rpc;
      model_reset(RST_PC);
      repeat (2) @(negedge CLK);
      #1;
      check("rst_req", IMEM_REQ, 0);
      check("rst_out", {Instr_VALID_IF, Instr1_IF, Instr_PC_IF, Instr_PC_Plus4_IF}, '0);
      @(negedge CLK);
      RESET = 1;
      #1;
      check("rel_req", {IMEM_REQ, IMEM_ADDR}, {1'b1, RST_PC});
      step(0, 0, 0, 0, 0, 0, 1);
      a0 = n_acc;
      for (int i = 0; i < 6; i++) begin
         step(1, 0, 0, 0, 1, 1, 0);
         if (i >= 2) check("stall_head", Instr_PC_IF, RST_PC);
      end
      check("stall_acc", n_acc - a0, 2);
      check("stall_req", IMEM_REQ, 0);
      repeat (2) step(0, 0, 0, 0, 0, 1, 0);
      repeat (4) step(1, 0, 0, 0, 1, 1, 0);
      check("pre_flush_head", Instr_PC_IF, 32'h0040_0008);
      step(1, 1, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      check("flush_replay", {Instr_VALID_IF, IMEM_REQ, IMEM_ADDR}, {2'b01, 32'h0040_0008});
      repeat (10) step(0, 0, 0, 0, 1, 1, 0);
      k = 0;
      while (pend_q.size() != 0 && k < 5) begin
         step(0, 0, 0, 0, 0, 1, 0);
         k++;
      end
      step(0, 0, 0, 0, 0, 1, 0);
      a_hold = IMEM_ADDR;
      repeat (2) begin
         step(0, 0, 0, 0, 0, 1, 0);
         check("rdy_low", {IMEM_REQ, IMEM_ADDR}, {1'b1, a_hold});
      end
      step(0, 0, 0, 0, 1, 1, 0);
      check("rdy_acc", {IMEM_REQ, IMEM_ADDR}, {1'b1, a_hold});
      step(0, 0, 1, 32'h0040_1002, 1, 0, 0);
      step(0, 0, 0, 0, 1, 1, 0);
      check("drop_req", IMEM_REQ, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      check("redir_addr", {IMEM_REQ, IMEM_ADDR}, {1'b1, 32'h0040_1000});
      repeat (6) step(0, 0, 0, 0, 1, 1, 0);
      for (int i = 0; i < 400; i++) begin
         rpc = $urandom_range(3) == 0 ? 32'hFFFF_FFE0 | 32'($urandom_range(31)) : $urandom;
         step($urandom_range(99) < 30, $urandom_range(99) < 4, $urandom_range(99) < 3, rpc,
              $urandom_range(99) < 70, $urandom_range(99) < 60, 0);
      end
      repeat (2) step(0, 0, 0, 0, 0, 1, 0);
      k = 0;
      while (pend_q.size() == 0 && k < 10) begin
         step(0, 0, 0, 0, 1, 0, 0);
         k++;
      end
      check("wait_reached", pend_q.size() != 0, 1);
      @(negedge CLK);
      RESET = 0;
      STALL = 0;
      FLUSH = 0;
      REDIRECT_VALID = 0;
      IMEM_RVALID = 0;
      #1;
      check("rst_wait", {IMEM_REQ, Instr_VALID_IF, Instr1_IF, Instr_PC_IF, Instr_PC_Plus4_IF}, '0);
      model_reset(RST_PC);
      repeat (2) @(negedge CLK);
      RESET = 1;
      #1;
      check("rerelease", {IMEM_REQ, IMEM_ADDR}, {1'b1, RST_PC});
      repeat (10) step(0, 0, 0, 0, 1, 1, 0);
      check("liveness", n_cons >= 40, 1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
